coffee_brew_sequencer: RTL
==========================

Name: coffee_brew_sequencer

Overview:
- Timed brew controller that drives the coffee-maker actuator outputs p, m, w, c, s, st and f.
- Latches one of six drink recipes on a start request and waits for a cup.
- Runs the phases pump -> dispense -> sugar -> stir, each for a programmed number of cycles, then signals completion.
- Sits between the front-panel/user logic and the actuator drivers. Handles cup removal, abort and invalid selections.

Parameters:
- PUMP_CYC, 4, cycles p is held high (1..65535)
- DISPENSE_CYC, 6, cycles the recipe's m/w/c outputs are held high (1..65535)
- SUGAR_CYC, 2, cycles s is held high when the recipe has sugar (1..65535)
- STIR_CYC, 3, cycles st is held high when the recipe stirs (1..65535)
- CUP_TIMEOUT, 10, maximum cycles spent waiting for a cup before error (1..65535)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  brew request, sampled only in IDLE
- drink_sel  in  3  recipe code: 0=mwis 1=mwos 2=ewis 3=ewos 4=cwis 5=cwos; 6,7 invalid
- cup_present  in  1  cup-on-stand sensor, level
- abort  in  1  cancel; highest priority after rst
- err_clr  in  1  clears ERROR back to IDLE
- p,m,w,c,s,st  out  1 each  actuator enables (pump, milk, water, coffee, sugar, stir)
- f  out  1  finish: one-cycle pulse in DONE
- busy  out  1  high in every state except IDLE and ERROR
- err  out  1  high while in ERROR
- phase  out  3  state code: IDLE=0 WAIT_CUP=1 PUMP=2 DISPENSE=3 SUGAR=4 STIR=5 DONE=6 ERROR=7

Behaviour:
- Reset: state=IDLE, down-counter=0, latched recipe=0. All outputs 0 on the cycle after rst is sampled high. Reset overrides everything, including mid-brew.
- All outputs are Moore, decoded from registered state and the latched recipe. No combinational path from any input to any output.
- Recipe table (milk, water, coffee, sugar, stir):
  - mwis 1,0,0,1,1
  - mwos 1,0,0,0,0
  - ewis 0,1,1,1,1
  - ewos 0,1,1,0,1
  - cwis 1,0,1,1,1
  - cwos 1,0,1,0,1
- Down-counter: 16 bits. It is loaded with N-1 on entry to a timed state, so the state lasts exactly N cycles. The state exits on the cycle after the counter reads 0.
- IDLE:
  - start=1 latches drink_sel.
  - Code 6 or 7 -> ERROR. Otherwise -> WAIT_CUP, loaded with CUP_TIMEOUT-1.
- WAIT_CUP:
  - cup_present=1 -> PUMP.
  - Counter reaching 0 with no cup -> ERROR.
  - Actuators stay off.
- PUMP: p=1 -> DISPENSE.
- DISPENSE: m/w/c per recipe. Exit:
  - sugar=1 -> SUGAR
  - else stir=1 -> STIR
  - else -> DONE
- SUGAR: s=1. Exit: stir=1 -> STIR, else -> DONE.
- STIR: st=1 -> DONE.
- DONE: f=1 for exactly one cycle, all actuators 0, then -> IDLE. A start in DONE is ignored.
- Cup removal: cup_present=0 sampled in PUMP, DISPENSE, SUGAR or STIR -> ERROR next cycle. Actuators are 0 from that cycle on.
- abort=1 in any state except IDLE -> IDLE next cycle. All outputs 0, no f pulse, err cleared.
- ERROR: err=1, all actuators 0, start ignored. Leaves to IDLE only when err_clr=1 (or abort).
- Priority when inputs coincide: rst > abort > cup removal > counter expiry.
- start held high is level-sensitive only in IDLE. A held start re-triggers a new brew on the cycle after returning to IDLE.
- Counter wrap-around is impossible: it is reloaded on every timed-state entry and is never decremented below 0.

Test Plan:
- ewis with default params, cup_present=1 throughout, start pulse at cycle 0 -> WAIT_CUP at cycle 1; p high cycles 2-5; w,c high 6-11; s high 12-13; st high 14-16; f high at cycle 17 only; IDLE at 18.
- mwos with cup present, start at cycle 0 -> p cycles 2-5; m cycles 6-11; SUGAR and STIR skipped; f at cycle 12; s and st never assert.
- ewos, start at cycle 0, cup never placed -> WAIT_CUP for 10 cycles (1-10); ERROR with err=1 at cycle 11; stays in ERROR until err_clr=1, then IDLE next cycle.
- cwis with cup_present dropped during DISPENSE at cycle 8 -> ERROR at cycle 9 with m=c=0; no f pulse. Separately, drink_sel=7 with start -> ERROR at cycle 1.
- abort asserted during STIR, and separately rst asserted during PUMP -> all outputs 0 and phase=0 on the next cycle. A fresh cwos afterwards completes normally with f at cycle 15.

Source files
------------

// File: rtl/coffee_brew_sequencer.sv
// Coffee brew sequencer: latches a recipe on start, waits for a cup, then runs
// pump -> dispense -> sugar -> stir on a shared 16-bit down-counter and pulses f.
//
// state    | meaning
// IDLE     | waiting for start
// WAIT_CUP | recipe latched, waiting for the cup sensor (bounded by CUP_TIMEOUT)
// PUMP     | p on for PUMP_CYC cycles
// DISPENSE | recipe m/w/c on for DISPENSE_CYC cycles
// SUGAR    | s on for SUGAR_CYC cycles (sugar recipes only)
// STIR     | st on for STIR_CYC cycles (stirring recipes only)
// DONE     | one-cycle finish pulse on f
// ERROR    | timeout, cup removal or bad selection; held until err_clr or abort
module coffee_brew_sequencer #(
  parameter int PUMP_CYC     = 4,
  parameter int DISPENSE_CYC = 6,
  parameter int SUGAR_CYC    = 2,
  parameter int STIR_CYC     = 3,
  parameter int CUP_TIMEOUT  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] drink_sel,
  input  logic       cup_present,
  input  logic       abort,
  input  logic       err_clr,
  output logic       p,
  output logic       m,
  output logic       w,
  output logic       c,
  output logic       s,
  output logic       st,
  output logic       f,
  output logic       busy,
  output logic       err,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CUP = 3'd1,
    PUMP     = 3'd2,
    DISPENSE = 3'd3,
    SUGAR    = 3'd4,
    STIR     = 3'd5,
    DONE     = 3'd6,
    ERROR    = 3'd7
  } state_t;

  localparam logic [15:0] PUMP_LD  = 16'(PUMP_CYC - 1);
  localparam logic [15:0] DISP_LD  = 16'(DISPENSE_CYC - 1);
  localparam logic [15:0] SUGAR_LD = 16'(SUGAR_CYC - 1);
  localparam logic [15:0] STIR_LD  = 16'(STIR_CYC - 1);
  localparam logic [15:0] CUP_LD   = 16'(CUP_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  rec, rec_nxt;
  logic [4:0]  rcp_cur, rcp_nxt;

  // Recipe bits are {milk, water, coffee, sugar, stir}; codes 6/7 decode to nothing.
  function automatic logic [4:0] recipe(input logic [2:0] code);
    case (code)
      3'd0:    recipe = 5'b10011;
      3'd1:    recipe = 5'b10000;
      3'd2:    recipe = 5'b01111;
      3'd3:    recipe = 5'b01101;
      3'd4:    recipe = 5'b10111;
      3'd5:    recipe = 5'b10101;
      default: recipe = 5'b00000;
    endcase
  endfunction

  assign rcp_cur = recipe(rec);
  assign rcp_nxt = recipe(rec_nxt);
  assign phase   = state;

  // Next-state and counter logic; priority is abort, then cup removal, then expiry.
  always_comb begin
    state_nxt = state;
    rec_nxt   = rec;
    cnt_nxt   = (cnt != 16'd0) ? cnt - 16'd1 : 16'd0;
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      cnt_nxt   = 16'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt = 16'd0;
          if (start) begin
            rec_nxt = drink_sel;
            if (drink_sel > 3'd5) begin
              state_nxt = ERROR;
            end else begin
              state_nxt = WAIT_CUP;
              cnt_nxt   = CUP_LD;
            end
          end
        end
        WAIT_CUP: begin
          if (cup_present) begin
            state_nxt = PUMP;
            cnt_nxt   = PUMP_LD;
          end else if (cnt == 16'd0) begin
            state_nxt = ERROR;
          end
        end
        PUMP, DISPENSE, SUGAR, STIR: begin
          if (!cup_present) begin
            state_nxt = ERROR;
            cnt_nxt   = 16'd0;
          end else if (cnt == 16'd0) begin
            case (state)
              PUMP: begin
                state_nxt = DISPENSE;
                cnt_nxt   = DISP_LD;
              end
              DISPENSE: begin
                if (rcp_cur[1]) begin
                  state_nxt = SUGAR;
                  cnt_nxt   = SUGAR_LD;
                end else if (rcp_cur[0]) begin
                  state_nxt = STIR;
                  cnt_nxt   = STIR_LD;
                end else begin
                  state_nxt = DONE;
                end
              end
              SUGAR: begin
                if (rcp_cur[0]) begin
                  state_nxt = STIR;
                  cnt_nxt   = STIR_LD;
                end else begin
                  state_nxt = DONE;
                end
              end
              default: state_nxt = DONE;
            endcase
          end
        end
        DONE:    state_nxt = IDLE;
        ERROR: begin
          cnt_nxt = 16'd0;
          if (err_clr) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State registers plus outputs registered from the next state so they are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 16'd0;
      rec   <= 3'd0;
      p     <= 1'b0;
      m     <= 1'b0;
      w     <= 1'b0;
      c     <= 1'b0;
      s     <= 1'b0;
      st    <= 1'b0;
      f     <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rec   <= rec_nxt;
      p     <= (state_nxt == PUMP);
      m     <= (state_nxt == DISPENSE) && rcp_nxt[4];
      w     <= (state_nxt == DISPENSE) && rcp_nxt[3];
      c     <= (state_nxt == DISPENSE) && rcp_nxt[2];
      s     <= (state_nxt == SUGAR);
      st    <= (state_nxt == STIR);
      f     <= (state_nxt == DONE);
      busy  <= (state_nxt != IDLE) && (state_nxt != ERROR);
      err   <= (state_nxt == ERROR);
    end
  end

endmodule
